execute_stage: RTL and testbench

Y86-64 execute stage. It holds the E pipeline register and applies the bubble request from `pipeline_control`. It contains the ALU, the condition-code register and the condition evaluator. It sits between decode and the M register, and it returns `E_icode`, `E_dstM` and `e_Cnd` to `pipeline_control`, which uses them for hazard and mispredict decisions.

---
 rtl/execute_stage.sv | 173 +++++++++++++++++
 tb/tb_execute_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: Y86-64 execute stage.
// Holds the E pipeline register, the ALU, the condition-code register and the
// branch/cmov condition evaluator.
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   E_bubble             load a nop into E instead of the decode values
//   setcc                permits a CC write this cycle
//   d_stat/d_icode/...   decode-stage values captured into E
//   E_stat/E_icode/E_ifun/E_dstM/E_valA   registered E fields
//   e_valE               ALU result (combinational from E)
//   e_dstE               destination after the cmov decision
//   e_Cnd                condition result
//   cc                   condition codes {ZF,SF,OF}
module execute_stage #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         E_bubble,
  input  logic         setcc,
  input  logic [0:3]   d_stat,
  input  logic [3:0]   d_icode,
  input  logic [3:0]   d_ifun,
  input  logic [W-1:0] d_valC,
  input  logic [W-1:0] d_valA,
  input  logic [W-1:0] d_valB,
  input  logic [3:0]   d_dstE,
  input  logic [3:0]   d_dstM,
  output logic [0:3]   E_stat,
  output logic [3:0]   E_icode,
  output logic [3:0]   E_ifun,
  output logic [3:0]   E_dstM,
  output logic [W-1:0] E_valA,
  output logic [W-1:0] e_valE,
  output logic [3:0]   e_dstE,
  output logic         e_Cnd,
  output logic [2:0]   cc
);

  localparam logic [0:3] STAT_AOK = 4'b1000;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [W-1:0] MINUS_EIGHT = {{(W-4){1'b1}}, 4'b1000};
  localparam logic [W-1:0] PLUS_EIGHT  = {{(W-4){1'b0}}, 4'b1000};

  logic [W-1:0] e_valc_r;
  logic [W-1:0] e_valb_r;
  logic [3:0]   e_dste_r;

  logic [W-1:0] alu_a_s;
  logic [W-1:0] alu_b_s;
  logic         zf_s;
  logic         sf_s;
  logic         of_s;
  logic         cond_s;

  // E pipeline register: reset and bubble both load a nop; E never stalls.
  always_ff @(posedge clk) begin
    if (rst || E_bubble) begin
      E_stat   <= STAT_AOK;
      E_icode  <= I_NOP;
      E_ifun   <= 4'h0;
      e_valc_r <= {W{1'b0}};
      E_valA   <= {W{1'b0}};
      e_valb_r <= {W{1'b0}};
      e_dste_r <= REG_NONE;
      E_dstM   <= REG_NONE;
    end else begin
      E_stat   <= d_stat;
      E_icode  <= d_icode;
      E_ifun   <= d_ifun;
      e_valc_r <= d_valC;
      E_valA   <= d_valA;
      e_valb_r <= d_valB;
      e_dste_r <= d_dstE;
      E_dstM   <= d_dstM;
    end
  end

  // ALU operand selection.
  always_comb begin
    alu_a_s = {W{1'b0}};
    alu_b_s = {W{1'b0}};
    case (E_icode)
      I_RRMOVQ, I_OPQ:             alu_a_s = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a_s = e_valc_r;
      I_CALL, I_PUSHQ:             alu_a_s = MINUS_EIGHT;
      I_RET, I_POPQ:               alu_a_s = PLUS_EIGHT;
      default:                     alu_a_s = {W{1'b0}};
    endcase
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b_s = e_valb_r;
      default:                                                   alu_b_s = {W{1'b0}};
    endcase
  end

  // ALU function and overflow; non-OPq instructions always add.
  always_comb begin
    e_valE = {W{1'b0}};
    of_s   = 1'b0;
    if (E_icode == I_OPQ) begin
      case (E_ifun)
        4'h0: begin
          e_valE = alu_b_s + alu_a_s;
          of_s   = (alu_a_s[W-1] == alu_b_s[W-1]) && (e_valE[W-1] != alu_a_s[W-1]);
        end
        4'h1: begin
          e_valE = alu_b_s - alu_a_s;
          of_s   = (alu_a_s[W-1] != alu_b_s[W-1]) && (e_valE[W-1] != alu_b_s[W-1]);
        end
        4'h2:    e_valE = alu_b_s & alu_a_s;
        4'h3:    e_valE = alu_b_s ^ alu_a_s;
        default: e_valE = {W{1'b0}};
      endcase
    end else begin
      e_valE = alu_b_s + alu_a_s;
    end
    zf_s = (e_valE == {W{1'b0}});
    sf_s = e_valE[W-1];
  end

  // Condition-code register, written only by an OPq in E when permitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc <= 3'b100;
    end else if ((E_icode == I_OPQ) && setcc) begin
      cc <= {zf_s, sf_s, of_s};
    end else begin
      cc <= cc;
    end
  end

  // Condition evaluation from the current flags; cc = {ZF,SF,OF}.
  always_comb begin
    cond_s = 1'b0;
    case (E_ifun)
      4'h0:    cond_s = 1'b1;
      4'h1:    cond_s = (cc[1] ^ cc[0]) | cc[2];
      4'h2:    cond_s = cc[1] ^ cc[0];
      4'h3:    cond_s = cc[2];
      4'h4:    cond_s = ~cc[2];
      4'h5:    cond_s = ~(cc[1] ^ cc[0]);
      4'h6:    cond_s = ~(cc[1] ^ cc[0]) & ~cc[2];
      default: cond_s = 1'b0;
    endcase
    if ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) begin
      e_Cnd = cond_s;
    end else begin
      e_Cnd = 1'b0;
    end
  end

  // A cmov whose condition fails writes no register.
  always_comb begin
    if ((E_icode == I_RRMOVQ) && !e_Cnd) begin
      e_dstE = REG_NONE;
    end else begin
      e_dstE = e_dste_r;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic         E_bubble;
  logic         setcc;
  logic [0:3]   d_stat;
  logic [3:0]   d_icode;
  logic [3:0]   d_ifun;
  logic [W-1:0] d_valC;
  logic [W-1:0] d_valA;
  logic [W-1:0] d_valB;
  logic [3:0]   d_dstE;
  logic [3:0]   d_dstM;
  logic [0:3]   E_stat;
  logic [3:0]   E_icode;
  logic [3:0]   E_ifun;
  logic [3:0]   E_dstM;
  logic [W-1:0] E_valA;
  logic [W-1:0] e_valE;
  logic [3:0]   e_dstE;
  logic         e_Cnd;
  logic [2:0]   cc;

  int tests;
  int failed;

  execute_stage #(.W(W)) dut (
    .clk(clk), .rst(rst), .E_bubble(E_bubble), .setcc(setcc),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
    .d_dstE(d_dstE), .d_dstM(d_dstM),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_dstM(E_dstM),
    .E_valA(E_valA), .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd), .cc(cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [W-1:0] valc, input logic [W-1:0] vala,
                       input logic [W-1:0] valb, input logic [3:0] dste,
                       input logic [3:0] dstm);
    d_stat  = 4'b1000;
    d_icode = icode;
    d_ifun  = ifun;
    d_valC  = valc;
    d_valA  = vala;
    d_valB  = valb;
    d_dstE  = dste;
    d_dstM  = dstm;
  endtask

  task automatic test_reset();
    rst = 1'b1; E_bubble = 1'b0; setcc = 1'b1;
    drive(4'h6, 4'h1, 64'd0, 64'd5, 64'd3, 4'h4, 4'hF);
    tick(); tick();
    tests++; if (E_icode !== 4'h1) begin failed++; $display("FAIL reset_icode got %h exp 1", E_icode); end
    tests++; if (E_stat !== 4'b1000) begin failed++; $display("FAIL reset_stat got %b exp 1000", E_stat); end
    tests++; if (cc !== 3'b100) begin failed++; $display("FAIL reset_cc got %b exp 100", cc); end
    tests++; if (e_dstE !== 4'hF) begin failed++; $display("FAIL reset_dstE got %h exp F", e_dstE); end
    tests++; if (E_dstM !== 4'hF) begin failed++; $display("FAIL reset_dstM got %h exp F", E_dstM); end
    tests++; if (e_valE !== 64'd0) begin failed++; $display("FAIL reset_valE got %h exp 0", e_valE); end
    tests++; if (e_Cnd !== 1'b0) begin failed++; $display("FAIL reset_cnd got %b exp 0", e_Cnd); end
    rst = 1'b0;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    tick();
    tests++; if (cc !== 3'b100) begin failed++; $display("FAIL idle_cc got %b exp 100", cc); end
  endtask

  task automatic test_sub();
    setcc = 1'b1;
    drive(4'h6, 4'h1, 64'd0, 64'd5, 64'd3, 4'h4, 4'hF);
    tick();
    tests++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin failed++; $display("FAIL sub_valE got %h exp FFFFFFFFFFFFFFFE", e_valE); end
    tests++; if (e_dstE !== 4'h4) begin failed++; $display("FAIL sub_dstE got %h exp 4", e_dstE); end
    tests++; if (E_valA !== 64'd5) begin failed++; $display("FAIL sub_valA got %h exp 5", E_valA); end
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    tick();
    tests++; if (cc !== 3'b010) begin failed++; $display("FAIL sub_cc got %b exp 010", cc); end
  endtask

  task automatic test_add_jump();
    setcc = 1'b1;
    drive(4'h6, 4'h0, 64'd0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 4'h5, 4'hF);
    tick();
    tests++; if (e_valE !== 64'h8000_0000_0000_0000) begin failed++; $display("FAIL add_valE got %h exp 8000000000000000", e_valE); end
    drive(4'h7, 4'h1, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
    tick();
    tests++; if (cc !== 3'b011) begin failed++; $display("FAIL add_cc got %b exp 011", cc); end
    tests++; if (e_Cnd !== 1'b0) begin failed++; $display("FAIL jle got %b exp 0", e_Cnd); end
    drive(4'h7, 4'h2, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
    tick();
    tests++; if (e_Cnd !== 1'b0) begin failed++; $display("FAIL jl got %b exp 0", e_Cnd); end
    drive(4'h7, 4'h5, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
    tick();
    tests++; if (e_Cnd !== 1'b1) begin failed++; $display("FAIL jge got %b exp 1", e_Cnd); end
    drive(4'h7, 4'h6, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
    tick();
    tests++; if (e_Cnd !== 1'b1) begin failed++; $display("FAIL jg got %b exp 1", e_Cnd); end
    drive(4'h7, 4'h0, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
    tick();
    tests++; if (e_Cnd !== 1'b1) begin failed++; $display("FAIL jmp got %b exp 1", e_Cnd); end
    drive(4'h7, 4'h7, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
    tick();
    tests++; if (e_Cnd !== 1'b0) begin failed++; $display("FAIL jbad got %b exp 0", e_Cnd); end
    drive(4'h7, 4'h4, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
    tick();
    tests++; if (e_Cnd !== 1'b1) begin failed++; $display("FAIL jne got %b exp 1", e_Cnd); end
  endtask

  task automatic test_cmov();
    // flags are {0,1,1}: ZF clear, so cmove fails
    setcc = 1'b1;
    drive(4'h2, 4'h3, 64'd0, 64'h1234, 64'd0, 4'h3, 4'hF);
    tick();
    tests++; if (e_dstE !== 4'hF) begin failed++; $display("FAIL cmove_nz_dstE got %h exp F", e_dstE); end
    tests++; if (e_valE !== 64'h1234) begin failed++; $display("FAIL cmove_valE got %h exp 1234", e_valE); end
    drive(4'h6, 4'h3, 64'd0, 64'd7, 64'd7, 4'h4, 4'hF);
    tick();
    tests++; if (e_valE !== 64'd0) begin failed++; $display("FAIL xor_valE got %h exp 0", e_valE); end
    drive(4'h2, 4'h3, 64'd0, 64'h1234, 64'd0, 4'h3, 4'hF);
    tick();
    tests++; if (cc !== 3'b100) begin failed++; $display("FAIL xor_cc got %b exp 100", cc); end
    tests++; if (e_dstE !== 4'h3) begin failed++; $display("FAIL cmove_z_dstE got %h exp 3", e_dstE); end
    tests++; if (e_Cnd !== 1'b1) begin failed++; $display("FAIL cmove_z_cnd got %b exp 1", e_Cnd); end
  endtask

  task automatic test_bubble();
    drive(4'h5, 4'h0, 64'h10, 64'd0, 64'h20, 4'hF, 4'h2);
    E_bubble = 1'b1;
    tick();
    tests++; if (E_icode !== 4'h1) begin failed++; $display("FAIL bubble_icode got %h exp 1", E_icode); end
    tests++; if (E_dstM !== 4'hF) begin failed++; $display("FAIL bubble_dstM got %h exp F", E_dstM); end
    tests++; if (e_valE !== 64'd0) begin failed++; $display("FAIL bubble_valE got %h exp 0", e_valE); end
    E_bubble = 1'b0;
    tick();
    tests++; if (E_icode !== 4'h5) begin failed++; $display("FAIL mrmov_icode got %h exp 5", E_icode); end
    tests++; if (E_dstM !== 4'h2) begin failed++; $display("FAIL mrmov_dstM got %h exp 2", E_dstM); end
    tests++; if (e_valE !== 64'h30) begin failed++; $display("FAIL mrmov_valE got %h exp 30", e_valE); end
  endtask

  task automatic test_setcc_block();
    setcc = 1'b0;
    drive(4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 4'h4, 4'hF);
    tick();
    tests++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFF) begin failed++; $display("FAIL blk_valE got %h exp FFFFFFFFFFFFFFFF", e_valE); end
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    tick();
    tests++; if (cc !== 3'b100) begin failed++; $display("FAIL blk_cc got %b exp 100", cc); end
    setcc = 1'b1;
  endtask

  task automatic test_stack();
    drive(4'hA, 4'h0, 64'd0, 64'd0, 64'h100, 4'h4, 4'hF);
    tick();
    tests++; if (e_valE !== 64'hF8) begin failed++; $display("FAIL push_valE got %h exp F8", e_valE); end
    drive(4'hB, 4'h0, 64'd0, 64'd0, 64'h100, 4'h4, 4'h3);
    tick();
    tests++; if (e_valE !== 64'h108) begin failed++; $display("FAIL pop_valE got %h exp 108", e_valE); end
    drive(4'h8, 4'h0, 64'h500, 64'd0, 64'h0, 4'h4, 4'hF);
    tick();
    tests++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFF8) begin failed++; $display("FAIL call_valE got %h exp FFFFFFFFFFFFFFF8", e_valE); end
    drive(4'h9, 4'h0, 64'd0, 64'd0, 64'h200, 4'h4, 4'hF);
    tick();
    tests++; if (e_valE !== 64'h208) begin failed++; $display("FAIL ret_valE got %h exp 208", e_valE); end
  endtask

  task automatic test_logic();
    setcc = 1'b1;
    drive(4'h6, 4'h2, 64'd0, 64'hF0, 64'h3C, 4'h4, 4'hF);
    tick();
    tests++; if (e_valE !== 64'h30) begin failed++; $display("FAIL and_valE got %h exp 30", e_valE); end
    drive(4'h6, 4'h7, 64'd0, 64'hF0, 64'h3C, 4'h4, 4'hF);
    tick();
    tests++; if (e_valE !== 64'd0) begin failed++; $display("FAIL badfn_valE got %h exp 0", e_valE); end
    tests++; if (cc !== 3'b000) begin failed++; $display("FAIL and_cc got %b exp 000", cc); end
    drive(4'h6, 4'h1, 64'd0, 64'd1, 64'h8000_0000_0000_0000, 4'h4, 4'hF);
    tick();
    tests++; if (e_valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin failed++; $display("FAIL subov_valE got %h exp 7FFFFFFFFFFFFFFF", e_valE); end
    drive(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    d_stat = 4'b0100;
    tick();
    tests++; if (cc !== 3'b001) begin failed++; $display("FAIL subov_cc got %b exp 001", cc); end
    tests++; if (E_stat !== 4'b0100) begin failed++; $display("FAIL halt_stat got %b exp 0100", E_stat); end
    tests++; if (e_valE !== 64'd0) begin failed++; $display("FAIL halt_valE got %h exp 0", e_valE); end
  endtask

  task automatic test_reset_mid();
    setcc = 1'b1;
    drive(4'h6, 4'h1, 64'd0, 64'd5, 64'd3, 4'h4, 4'hF);
    tick();
    rst = 1'b1;
    E_bubble = 1'b1;
    tick();
    tests++; if (cc !== 3'b100) begin failed++; $display("FAIL rstmid_cc got %b exp 100", cc); end
    tests++; if (E_icode !== 4'h1) begin failed++; $display("FAIL rstmid_icode got %h exp 1", E_icode); end
    tests++; if (e_dstE !== 4'hF) begin failed++; $display("FAIL rstmid_dstE got %h exp F", e_dstE); end
    rst = 1'b0;
    E_bubble = 1'b0;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    test_reset();
    test_sub();
    test_add_jump();
    test_cmov();
    test_bubble();
    test_setcc_block();
    test_stack();
    test_logic();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
